// File: rtl/match_check_pkg.sv
// Shared game definitions for the 8-square colour-matching game: square
// indices, step codes, FSM state encoding, field widths and a colour lookup
// helper.
package match_check_pkg;

  localparam int COLOR_W = 3;
  localparam int SQUARES = 8;
  localparam int IDX_W   = 3;

  typedef logic [IDX_W-1:0]           sq_idx_t;
  typedef logic [COLOR_W-1:0]         color_t;
  typedef logic [COLOR_W*SQUARES-1:0] color_map_t;

  // Square indices
  localparam sq_idx_t kare0 = 3'd0;
  localparam sq_idx_t kare1 = 3'd1;
  localparam sq_idx_t kare2 = 3'd2;
  localparam sq_idx_t kare3 = 3'd3;
  localparam sq_idx_t kare4 = 3'd4;
  localparam sq_idx_t kare5 = 3'd5;
  localparam sq_idx_t kare6 = 3'd6;
  localparam sq_idx_t kare7 = 3'd7;

  // Game sequencer step codes
  localparam logic [3:0] STEP_START = 4'b0001;
  localparam logic [3:0] STEP_SEL1  = 4'b0010;
  localparam logic [3:0] STEP_SEL2  = 4'b0011;  // second selection active

  localparam logic [2:0] SCORE_MAX = 3'd4;
  localparam logic [7:0] MISS_MAX  = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CHECK,
    ST_SHOW,
    ST_ADVANCE
  } state_t;

  // Colour of one square, picked out of the packed colour map.
  function automatic color_t color_of(input color_map_t colors, input sq_idx_t idx);
    return colors[idx*COLOR_W +: COLOR_W];
  endfunction

endpackage

// File: rtl/match_check_if.sv
// Signal bundle between the game sequencer/selector side (master) and the
// match_check stage (slave).
interface match_check_if;
  import match_check_pkg::*;

  logic [3:0]         step_2;
  sq_idx_t            secim1;
  sq_idx_t            secim2;
  logic               confirm;
  color_map_t         colors;
  logic [SQUARES-1:0] matched;
  logic [2:0]         score;
  logic               reveal;
  logic               hit;
  logic               step_done;
  logic               game_over;
  logic [7:0]         miss_cnt;

  modport master (
    output step_2, secim1, secim2, confirm, colors,
    input  matched, score, reveal, hit, step_done, game_over, miss_cnt
  );

  modport slave (
    input  step_2, secim1, secim2, confirm, colors,
    output matched, score, reveal, hit, step_done, game_over, miss_cnt
  );
endinterface

// File: rtl/match_check_reveal_timer.sv
// Reveal hold timer: load clears the count, run advances it, and o_done is
// high on the last cycle of a SHOW_CYCLES-long run.
module reveal_timer #(
  parameter int SHOW_CYCLES = 25000000,
  parameter int CNT_W       = 25
) (
  input  logic clk25MHz,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_run,
  output logic o_done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SHOW_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  // Count register: clear on load, step while running.
  always_ff @(posedge clk25MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= '0;
    end else if (i_run) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_done = i_run && (r_count == LAST);

endmodule

// File: rtl/match_check.sv
// match_check: on a confirm edge during the second-selection step, compares
// the colours of the two selected squares, updates matched mask and score,
// holds both squares revealed for SHOW_CYCLES, then pulses step_done.
// Optional miss counter: define MATCH_CHECK_MISS_COUNTER_EN.
module match_check
  import match_check_pkg::*;
#(
  parameter logic [3:0] SEL_STEP    = STEP_SEL2,
  parameter int         SHOW_CYCLES = 25000000,
  parameter int         CNT_W       = 25
) (
  input logic         clk25MHz,
  input logic         rst_n,
  match_check_if.slave bus
);

  state_t             r_state;
  state_t             w_next;
  logic               r_confirm_q;
  sq_idx_t            r_a;
  sq_idx_t            r_b;
  logic [SQUARES-1:0] r_matched;
  logic [2:0]         r_score;
  logic               r_hit;
  logic               r_step_done;

  logic w_confirm_edge;
  logic w_in_step;
  logic w_pair_ok;
  logic w_accept;
  logic w_same_color;
  logic w_timer_done;

  assign w_confirm_edge = bus.confirm & ~r_confirm_q;
  assign w_in_step      = (bus.step_2 == SEL_STEP);
  assign w_pair_ok      = (bus.secim1 != bus.secim2) &&
                          !r_matched[bus.secim1] && !r_matched[bus.secim2];
  assign w_same_color   = (color_of(bus.colors, r_a) == color_of(bus.colors, r_b));

  reveal_timer #(
    .SHOW_CYCLES(SHOW_CYCLES),
    .CNT_W      (CNT_W)
  ) u_reveal_timer (
    .clk25MHz(clk25MHz),
    .rst_n   (rst_n),
    .i_load  (r_state == ST_CHECK),
    .i_run   (r_state == ST_SHOW),
    .o_done  (w_timer_done)
  );

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk25MHz or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode and selection acceptance.
  always_comb begin
    // NOTE: defaults first so every path assigns every output -- no latches.
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      ST_IDLE:    if (w_in_step) w_next = ST_ARMED;
      ST_ARMED: begin
        if (!w_in_step) begin
          w_next = ST_IDLE;
        end else if (w_confirm_edge && w_pair_ok) begin
          w_accept = 1'b1;
          w_next   = ST_CHECK;
        end
      end
      ST_CHECK:   w_next = ST_SHOW;
      ST_SHOW:    if (w_timer_done) w_next = ST_ADVANCE;
      ST_ADVANCE: w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Confirm edge register, selection latch, mask/score update and pulses.
  always_ff @(posedge clk25MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_confirm_q <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_matched   <= '0;
      r_score     <= '0;
      r_hit       <= 1'b0;
      r_step_done <= 1'b0;
    end else begin
      r_confirm_q <= bus.confirm;
      r_hit       <= (r_state == ST_CHECK) && w_same_color;
      r_step_done <= (r_state == ST_ADVANCE);
      if (w_accept) begin
        r_a <= bus.secim1;
        r_b <= bus.secim2;
      end
      if ((r_state == ST_CHECK) && w_same_color) begin
        r_matched <= r_matched | (SQUARES'(1) << r_a) | (SQUARES'(1) << r_b);
        if (r_score != SCORE_MAX) r_score <= r_score + 1'b1;
      end
    end
  end

`ifdef MATCH_CHECK_MISS_COUNTER_EN
  logic [7:0] r_miss_cnt;

  // Saturating count of mismatched pairs.
  always_ff @(posedge clk25MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_miss_cnt <= '0;
    end else if ((r_state == ST_CHECK) && !w_same_color && (r_miss_cnt != MISS_MAX)) begin
      r_miss_cnt <= r_miss_cnt + 1'b1;
    end
  end

  assign bus.miss_cnt = r_miss_cnt;
`else
  assign bus.miss_cnt = '0;
`endif

  assign bus.matched   = r_matched;
  assign bus.score     = r_score;
  assign bus.reveal    = (r_state == ST_SHOW);
  assign bus.hit       = r_hit;
  assign bus.step_done = r_step_done;
  assign bus.game_over = &r_matched;

endmodule

// File: tb/tb_match_check.sv
// Scoreboard bench for match_check: the driver predicts each accepted
// selection's outcome and queues it; the monitor pops and compares when the
// DUT pulses step_done.
module tb_match_check;
  import match_check_pkg::*;

  localparam int SHOW     = 8;
  localparam int CNT_W    = 4;
  localparam int HIT_LAT  = 2;
  localparam int DONE_LAT = SHOW + 3;

  typedef struct {
    bit         exp_hit;
    logic [7:0] matched;
    logic [2:0] score;
    logic [7:0] miss;
    bit         game_over;
    int         edge_cyc;
  } exp_t;

  logic clk25MHz = 1'b0;
  logic rst_n    = 1'b0;

  match_check_if bus();

  match_check #(
    .SHOW_CYCLES(SHOW),
    .CNT_W      (CNT_W)
  ) dut (
    .clk25MHz(clk25MHz),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #20 clk25MHz = ~clk25MHz;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  exp_t sb[$];
  exp_t e_mon;

  logic [23:0] colors_v = 24'o11223344;
  logic [7:0]  m_matched;
  logic [2:0]  m_score;
  logic [7:0]  m_miss;

  always @(posedge clk25MHz) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] col(input logic [2:0] idx);
    return colors_v[idx*3 +: 3];
  endfunction

  // Monitor
  bit seen_hit;
  int hit_cyc;
  int reveal_len;
  int total_dones  = 0;
  int total_reveal = 0;

  always @(negedge clk25MHz) begin
    if (!rst_n) begin
      seen_hit   = 1'b0;
      reveal_len = 0;
    end else begin
      if (bus.reveal) begin
        reveal_len++;
        total_reveal++;
      end
      if (bus.hit) begin
        seen_hit = 1'b1;
        hit_cyc  = cyc;
      end
      if (bus.step_done) begin
        total_dones++;
        if (sb.size() == 0) begin
          check("spurious_step_done", 32'd1, 32'd0);
        end else begin
          e_mon = sb.pop_front();
          check("hit_seen", 32'(seen_hit), 32'(e_mon.exp_hit));
          if (e_mon.exp_hit) check("hit_latency", 32'(hit_cyc - e_mon.edge_cyc), 32'(HIT_LAT));
          check("done_latency", 32'(cyc - e_mon.edge_cyc), 32'(DONE_LAT));
          check("reveal_len", 32'(reveal_len), 32'(SHOW));
          check("matched", 32'(bus.matched), 32'(e_mon.matched));
          check("score", 32'(bus.score), 32'(e_mon.score));
          check("game_over", 32'(bus.game_over), 32'(e_mon.game_over));
          check("miss_cnt", 32'(bus.miss_cnt), 32'(e_mon.miss));
        end
        seen_hit   = 1'b0;
        reveal_len = 0;
      end
    end
  end

  task automatic check_cleared(input string pfx);
    check({pfx, "_matched"},   32'(bus.matched),   32'd0);
    check({pfx, "_score"},     32'(bus.score),     32'd0);
    check({pfx, "_reveal"},    32'(bus.reveal),    32'd0);
    check({pfx, "_hit"},       32'(bus.hit),       32'd0);
    check({pfx, "_step_done"}, 32'(bus.step_done), 32'd0);
    check({pfx, "_game_over"}, 32'(bus.game_over), 32'd0);
    check({pfx, "_miss_cnt"},  32'(bus.miss_cnt),  32'd0);
  endtask

  // Drive one confirm with the given pair; hold = cycles confirm stays high;
  // disturb = fire another edge and drop step_2 while the reveal is running.
  task automatic play(input logic [2:0] s1, input logic [2:0] s2, input int hold, input bit disturb);
    bit   acc;
    exp_t e;
    int   d0;
    int   r0;
    int   wait_n;
    acc = (bus.step_2 == STEP_SEL2) && (s1 != s2) && !m_matched[s1] && !m_matched[s2];
    d0  = total_dones;
    r0  = total_reveal;
    @(negedge clk25MHz);
    bus.secim1  = s1;
    bus.secim2  = s2;
    bus.confirm = 1'b1;
    if (acc) begin
      e.exp_hit = (col(s1) == col(s2));
      if (e.exp_hit) begin
        m_matched = m_matched | (8'd1 << s1) | (8'd1 << s2);
        if (m_score != 3'd4) m_score = m_score + 3'd1;
      end else begin
`ifdef MATCH_CHECK_MISS_COUNTER_EN
        if (m_miss != 8'hFF) m_miss = m_miss + 8'd1;
`endif
      end
      e.matched   = m_matched;
      e.score     = m_score;
      e.miss      = m_miss;
      e.game_over = (m_matched == 8'hFF);
      e.edge_cyc  = cyc;
      sb.push_back(e);
    end
    repeat (hold) @(negedge clk25MHz);
    bus.confirm = 1'b0;
    if (disturb) begin
      repeat (3) @(negedge clk25MHz);
      bus.secim1  = 3'd4;
      bus.secim2  = 3'd5;
      bus.confirm = 1'b1;
      bus.step_2  = 4'd0;
      @(negedge clk25MHz);
      bus.confirm = 1'b0;
      @(negedge clk25MHz);
      bus.step_2  = STEP_SEL2;
    end
    wait_n = 0;
    while (sb.size() != 0 && wait_n < 60) begin
      @(negedge clk25MHz);
      wait_n++;
    end
    check("txn_pending", 32'(sb.size()), 32'd0);
    sb.delete();
    repeat (14) @(negedge clk25MHz);
    check("done_count", 32'(total_dones - d0), acc ? 32'd1 : 32'd0);
    check("reveal_cycles", 32'(total_reveal - r0), acc ? 32'(SHOW) : 32'd0);
  endtask

  initial begin
    int d0;
    bus.step_2  = 4'd0;
    bus.secim1  = '0;
    bus.secim2  = '0;
    bus.confirm = 1'b0;
    bus.colors  = colors_v;
    m_matched   = '0;
    m_score     = '0;
    m_miss      = '0;

    #5;
    check_cleared("reset");
    repeat (2) @(negedge clk25MHz);
    rst_n      = 1'b1;
    bus.step_2 = STEP_SEL2;
    repeat (2) @(negedge clk25MHz);

    play(kare0, kare2, 1, 1'b0);   // colour mismatch
    play(kare0, kare1, 1, 1'b1);   // match, with ignored edge during reveal
    play(kare5, kare5, 1, 1'b0);   // same square: rejected
    play(kare0, kare3, 1, 1'b0);   // square 0 already matched: rejected

    bus.step_2 = STEP_SEL1;        // wrong step: rejected
    repeat (2) @(negedge clk25MHz);
    play(kare2, kare3, 1, 1'b0);
    bus.step_2 = STEP_SEL2;
    repeat (2) @(negedge clk25MHz);

    play(kare2, kare3, 20, 1'b0);  // held button: one sequence only
    play(kare4, kare5, 1, 1'b0);
    play(kare6, kare7, 1, 1'b0);
    check("final_matched",   32'(bus.matched),   32'hFF);
    check("final_score",     32'(bus.score),     32'd4);
    check("final_game_over", 32'(bus.game_over), 32'd1);
    play(kare6, kare7, 1, 1'b0);   // fifth confirm: rejected
    check("score_hold", 32'(bus.score), 32'd4);

    // Reset clears everything, then abort a reveal with reset.
    @(negedge clk25MHz);
    rst_n = 1'b0;
    #1;
    check_cleared("reset2");
    @(negedge clk25MHz);
    rst_n     = 1'b1;
    m_matched = '0;
    m_score   = '0;
    m_miss    = '0;
    repeat (2) @(negedge clk25MHz);

    d0 = total_dones;
    bus.secim1  = kare0;
    bus.secim2  = kare1;
    bus.confirm = 1'b1;
    @(negedge clk25MHz);
    bus.confirm = 1'b0;
    repeat (4) @(negedge clk25MHz);
    check("pre_abort_reveal",  32'(bus.reveal),  32'd1);
    check("pre_abort_matched", 32'(bus.matched), 32'h03);
    rst_n = 1'b0;
    #1;
    check_cleared("abort");
    @(negedge clk25MHz);
    rst_n = 1'b1;
    repeat (20) @(negedge clk25MHz);
    check("abort_no_done",    32'(total_dones - d0), 32'd0);
    check("abort_matched",    32'(bus.matched),      32'd0);
    check("abort_sb_empty",   32'(sb.size()),        32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
